// File: rtl/picomips_pkg.sv
// Shared types for the picoMIPS sequencing controller: opcodes, ALU codes, decode record and
// FSM states.
package picomips_pkg;

  localparam int unsigned OpWidth = 4;

  typedef enum logic [OpWidth-1:0] {
    OpNop   = 4'd0,
    OpAdd   = 4'd1,
    OpAddi  = 4'd2,
    OpSub   = 4'd3,
    OpSubi  = 4'd4,
    OpMuli  = 4'd5,
    OpBeq   = 4'd6,
    OpJ     = 4'd7,
    OpWaith = 4'd8,
    OpWaitl = 4'd9,
    OpHalt  = 4'd15
  } opcode_t;

  typedef logic [2:0] alufunc_t;

  localparam alufunc_t AluAdd  = 3'b000;
  localparam alufunc_t AluSub  = 3'b001;
  localparam alufunc_t AluMul  = 3'b010;
  localparam alufunc_t AluPass = 3'b011;

  typedef enum logic [2:0] {
    ClsNop,
    ClsAlu,
    ClsMul,
    ClsBeq,
    ClsJmp,
    ClsWaitH,
    ClsWaitL,
    ClsHalt
  } op_class_t;

  typedef struct packed {
    op_class_t cls;
    alufunc_t  alufunc;
    logic      imm;
    logic      writes;
  } decode_t;

  typedef enum logic [1:0] {
    StExec,
    StMulw,
    StWaitw,
    StHalted
  } state_t;

endpackage

// File: rtl/picomips_decode.sv
// Combinational opcode decoder; unlisted opcodes decode as NOP.
module picomips_decode
  import picomips_pkg::*;
(
  input  logic [OpWidth-1:0] opcode_i,
  output decode_t            dec_o
);

  always_comb begin
    dec_o.cls     = ClsNop;
    dec_o.alufunc = AluAdd;
    dec_o.imm     = 1'b0;
    dec_o.writes  = 1'b0;
    case (opcode_i)
      OpAdd: begin
        dec_o.cls    = ClsAlu;
        dec_o.writes = 1'b1;
      end
      OpAddi: begin
        dec_o.cls    = ClsAlu;
        dec_o.imm    = 1'b1;
        dec_o.writes = 1'b1;
      end
      OpSub: begin
        dec_o.cls     = ClsAlu;
        dec_o.alufunc = AluSub;
        dec_o.writes  = 1'b1;
      end
      OpSubi: begin
        dec_o.cls     = ClsAlu;
        dec_o.alufunc = AluSub;
        dec_o.imm     = 1'b1;
        dec_o.writes  = 1'b1;
      end
      OpMuli: begin
        dec_o.cls     = ClsMul;
        dec_o.alufunc = AluMul;
        dec_o.imm     = 1'b1;
        dec_o.writes  = 1'b1;
      end
      OpBeq:   dec_o.cls = ClsBeq;
      OpJ:     dec_o.cls = ClsJmp;
      OpWaith: dec_o.cls = ClsWaitH;
      OpWaitl: dec_o.cls = ClsWaitL;
      OpHalt:  dec_o.cls = ClsHalt;
      default: dec_o.cls = ClsNop;
    endcase
  end

endmodule

// File: rtl/picomips_ctrl.sv
// picoMIPS sequencing controller: drives PC strobes and datapath controls, stalling the PC for
// multi-cycle multiplies, switch waits and HALT.
module picomips_ctrl
  import picomips_pkg::*;
#(
  parameter int unsigned Osize     = OpWidth,
  parameter int unsigned MulCycles = 3
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [Osize-1:0] opcode,
  input  logic             Z,
  input  logic             go,
  output logic             PCincr,
  output logic             PCrelbranch,
  output logic             PCabsbranch,
  output logic             w,
  output logic             imm,
  output logic [2:0]       ALUfunc,
  output logic             mul_en,
  output logic             busy
);

  // cnt counts the MULW cycles still to go after the current one.
  localparam logic [3:0] CntLoad = (MulCycles > 1) ? 4'(MulCycles - 2) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  decode_t    dec;

  picomips_decode u_decode (
    .opcode_i (opcode),
    .dec_o    (dec)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StExec;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCincr      = 1'b0;
    PCrelbranch = 1'b0;
    PCabsbranch = 1'b0;
    w           = 1'b0;
    imm         = 1'b0;
    ALUfunc     = AluAdd;
    mul_en      = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      StExec: begin
        unique case (dec.cls)
          ClsAlu: begin
            w       = dec.writes;
            imm     = dec.imm;
            ALUfunc = dec.alufunc;
            PCincr  = 1'b1;
          end
          ClsNop: PCincr = 1'b1;
          ClsBeq: begin
            PCrelbranch = Z;
            PCincr      = !Z;
          end
          ClsJmp: PCabsbranch = 1'b1;
          ClsMul: begin
            mul_en = 1'b1;
            imm    = dec.imm;
            if (MulCycles > 1) begin
              cnt_d   = CntLoad;
              state_d = StMulw;
            end else begin
              w       = dec.writes;
              ALUfunc = dec.alufunc;
              PCincr  = 1'b1;
            end
          end
          ClsWaitH: begin
            if (go) PCincr = 1'b1;
            else    state_d = StWaitw;
          end
          ClsWaitL: begin
            if (!go) PCincr = 1'b1;
            else     state_d = StWaitw;
          end
          ClsHalt: state_d = StHalted;
          default: PCincr = 1'b1;
        endcase
      end
      StMulw: begin
        mul_en = 1'b1;
        imm    = 1'b1;
        busy   = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          w       = 1'b1;
          ALUfunc = AluMul;
          PCincr  = 1'b1;
          state_d = StExec;
        end
      end
      StWaitw: begin
        busy = 1'b1;
        // PC is held, so the opcode still names the wait instruction.
        if ((dec.cls == ClsWaitH) ? go : !go) begin
          PCincr  = 1'b1;
          state_d = StExec;
        end
      end
      StHalted: busy = 1'b1;
      default: state_d = StExec;
    endcase
  end

endmodule

// File: tb/tb_picomips_ctrl.sv
// Scoreboard bench for picomips_ctrl: two instances (3-cycle and 1-cycle multiply) share
// stimulus; a behavioural model queues expected outputs, a monitor compares every cycle.
module tb_picomips_ctrl;

  localparam int MC0 = 3;
  localparam int MC1 = 1;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] opcode;
  logic       Z, go;

  logic       pci0, rel0, abs0, w0, imm0, me0, bsy0;
  logic [2:0] alu0;
  logic       pci1, rel1, abs1, w1, imm1, me1, bsy1;
  logic [2:0] alu1;

  always #5 clk = ~clk;

  picomips_ctrl #(.Osize(4), .MulCycles(MC0)) dut0 (
    .clk(clk), .nreset(nreset), .opcode(opcode), .Z(Z), .go(go),
    .PCincr(pci0), .PCrelbranch(rel0), .PCabsbranch(abs0), .w(w0), .imm(imm0),
    .ALUfunc(alu0), .mul_en(me0), .busy(bsy0)
  );

  picomips_ctrl #(.Osize(4), .MulCycles(MC1)) dut1 (
    .clk(clk), .nreset(nreset), .opcode(opcode), .Z(Z), .go(go),
    .PCincr(pci1), .PCrelbranch(rel1), .PCabsbranch(abs1), .w(w1), .imm(imm1),
    .ALUfunc(alu1), .mul_en(me1), .busy(bsy1)
  );

  // {PCincr, PCrelbranch, PCabsbranch, w, imm, ALUfunc, mul_en, busy}
  logic [9:0] got0, got1;
  assign got0 = {pci0, rel0, abs0, w0, imm0, alu0, me0, bsy0};
  assign got1 = {pci1, rel1, abs1, w1, imm1, alu1, me1, bsy1};

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int checks = 0;
  int errors = 0;

  // Model state: multiply cycles still owed, waiting on the switch, halted.
  int mul_left[2];
  bit waiting[2];
  bit halted[2];

  task automatic model(input int k, input logic [3:0] op, input logic z, input logic g,
                       input logic n, output logic [9:0] e);
    logic pc, rb, ab, wr, im, me, bs;
    logic [2:0] af;
    int mc;
    mc = (k == 0) ? MC0 : MC1;
    {pc, rb, ab, wr, im, me, bs} = '0;
    af = 3'b000;
    if (halted[k]) begin
      bs = 1'b1;
    end else if (mul_left[k] > 0) begin
      bs = 1'b1; me = 1'b1; im = 1'b1;
      if (mul_left[k] == 1) begin
        wr = 1'b1; pc = 1'b1; af = 3'b010;
      end
      mul_left[k] = mul_left[k] - 1;
    end else if (waiting[k]) begin
      bs = 1'b1;
      if ((op == 4'd8) ? g : !g) begin
        pc = 1'b1;
        waiting[k] = 1'b0;
      end
    end else begin
      case (op)
        4'd1, 4'd3: begin wr = 1'b1; pc = 1'b1; af = (op == 4'd3) ? 3'b001 : 3'b000; end
        4'd2, 4'd4: begin
          wr = 1'b1; pc = 1'b1; im = 1'b1; af = (op == 4'd4) ? 3'b001 : 3'b000;
        end
        4'd5: begin
          me = 1'b1; im = 1'b1;
          if (mc == 1) begin wr = 1'b1; pc = 1'b1; af = 3'b010; end
          else mul_left[k] = mc - 1;
        end
        4'd6: begin rb = z; pc = !z; end
        4'd7: ab = 1'b1;
        4'd8: if (g) pc = 1'b1; else waiting[k] = 1'b1;
        4'd9: if (!g) pc = 1'b1; else waiting[k] = 1'b1;
        4'd15: halted[k] = 1'b1;
        default: pc = 1'b1;
      endcase
    end
    if (!n) begin
      halted[k] = 1'b0; waiting[k] = 1'b0; mul_left[k] = 0;
    end
    e = {pc, rb, ab, wr, im, af, me, bs};
  endtask

  task automatic step(input logic [3:0] op, input logic z, input logic g, input logic n);
    logic [9:0] e;
    @(posedge clk);
    #1;
    opcode = op; Z = z; go = g; nreset = n;
    model(0, op, z, g, n, e);
    q0.push_back(e);
    model(1, op, z, g, n, e);
    q1.push_back(e);
  endtask

  function automatic void check(input int k, input logic [9:0] e, input logic [9:0] g);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL dut%0d ctrl_outputs t=%0t op=%0d: got %b expected %b", k, $time,
               opcode, g, e);
    end
  endfunction

  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front(), got0);
    if (q1.size() > 0) check(1, q1.pop_front(), got1);
  end

  initial begin
    logic [3:0] cur;
    for (int k = 0; k < 2; k++) begin
      mul_left[k] = 0; waiting[k] = 1'b0; halted[k] = 1'b0;
    end
    nreset = 1'b0; opcode = 4'd0; Z = 1'b0; go = 1'b0;

    // Reset state, then directed sequences.
    step(4'd0, 0, 0, 0);
    step(4'd0, 0, 0, 1);
    step(4'd1, 0, 0, 1);
    step(4'd2, 0, 0, 1);
    step(4'd4, 0, 0, 1);
    step(4'd6, 1, 0, 1);
    step(4'd6, 0, 0, 1);
    step(4'd7, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(4'd5, 0, 0, 1);
    // Reset during the second multiply cycle discards the write.
    step(4'd5, 0, 0, 1);
    step(4'd5, 0, 0, 0);
    step(4'd1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(4'd8, 0, 0, 1);
    step(4'd8, 0, 1, 1);
    step(4'd9, 0, 0, 1);
    for (int i = 0; i < 101; i++) step(4'd15, 0, 0, 1);
    step(4'd15, 0, 0, 0);
    step(4'd1, 0, 0, 1);

    // Randomised program stream; the opcode holds while the PC is stalled.
    cur = 4'd0;
    for (int i = 0; i < 800; i++) begin
      logic n;
      n = ($urandom_range(0, 60) != 0);
      if (halted[0]) begin
        cur = 4'd15;
        if ($urandom_range(0, 7) == 0) n = 1'b0;
      end else if (mul_left[0] == 0 && !waiting[0]) begin
        cur = 4'($urandom_range(0, 15));
      end
      step(cur, 1'($urandom), 1'($urandom), n);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
